cache_ctrl: RTL and testbench

CACHE_CTRL -- requirements
Module: cache_ctrl

---
 rtl/cache_ctrl.sv | 227 ++++++++++++++++++++++
 tb/tb_cache_ctrl.sv | 341 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cache_ctrl.sv
// cache_ctrl -- blocking read-only cache controller for a 4-way, 8-set cache
// with 32-byte lines (eight 32-bit words). The tag and data arrays are
// external, with combinational read and synchronous write.
//
// Address split: tag = addr[31:8], index = addr[7:5], word = addr[4:2].
//
// Ports
//   clk, rst                         clock, asynchronous active-low reset
//   cpu_req_valid/ready, _addr       CPU read request
//   cpu_resp_valid/ready, _data      CPU read response
//   mem_req_valid/ready, _addr       refill request (block-aligned address)
//   mem_rdata_valid/ready, mem_rdata refill beats, word 0 first
//   tag_raddr/waddr, tag_wen,        tag array access (way w at
//   tag_wdata, tag_rdata, tag_valid  tag_rdata[24w+23:24w])
//   data_raddr/waddr, data_wen,      data array access (way w at
//   data_wdata, data_rdata           data_rdata[256w+255:256w])
//
// Build option
//   CACHE_PLRU_EN  defined: per-set 3-bit tree pseudo-LRU replacement.
//                  undefined: one global 2-bit round-robin victim counter
//                  that advances on every array write.

module cache_ctrl (
  input  logic          clk,
  input  logic          rst,
  input  logic          cpu_req_valid,
  output logic          cpu_req_ready,
  input  logic [31:0]   cpu_req_addr,
  output logic          cpu_resp_valid,
  input  logic          cpu_resp_ready,
  output logic [31:0]   cpu_resp_data,
  output logic          mem_req_valid,
  input  logic          mem_req_ready,
  output logic [31:0]   mem_req_addr,
  input  logic          mem_rdata_valid,
  output logic          mem_rdata_ready,
  input  logic [31:0]   mem_rdata,
  output logic [2:0]    tag_raddr,
  output logic [2:0]    tag_waddr,
  output logic [3:0]    tag_wen,
  output logic [23:0]   tag_wdata,
  input  logic [95:0]   tag_rdata,
  input  logic [3:0]    tag_valid,
  output logic [2:0]    data_raddr,
  output logic [2:0]    data_waddr,
  output logic [3:0]    data_wen,
  output logic [255:0]  data_wdata,
  input  logic [1023:0] data_rdata
);

  typedef enum logic [2:0] {IDLE, LOOKUP, MISS, REFILL, WRITE, RESP} state_e;

  state_e         state_q, state_d;
  logic [23:0]    tag_q;
  logic [2:0]     idx_q;
  logic [2:0]     off_q;
  logic [1:0]     victim_q;
  logic [2:0]     beat_q;
  logic [255:0]   line_q;
  logic [31:0]    resp_q;

  logic [3:0]     hit_vec;
  logic           hit;
  logic [1:0]     hit_way;
  logic           inv_found;
  logic [1:0]     inv_way;
  logic [1:0]     repl_way;
  logic [1:0]     miss_way;
  logic [9:0]     hit_sel;
  logic [31:0]    hit_word;
  logic           unused_addr_lsbs;

  // Byte-offset bits are not part of a word read.
  assign unused_addr_lsbs = ^cpu_req_addr[1:0];

  // Way compare and lowest-invalid-way search over the combinational array read.
  always_comb begin
    hit_vec   = '0;
    hit       = 1'b0;
    hit_way   = '0;
    inv_found = 1'b0;
    inv_way   = '0;
    for (int unsigned w = 0; w < 4; w++) begin
      hit_vec[w] = tag_valid[w] && (tag_rdata[24*w +: 24] == tag_q);
      if (hit_vec[w] && !hit) begin
        hit     = 1'b1;
        hit_way = 2'(w);
      end
      if (!tag_valid[w] && !inv_found) begin
        inv_found = 1'b1;
        inv_way   = 2'(w);
      end
    end
  end

  assign hit_sel  = {hit_way, off_q, 5'b0};
  assign hit_word = data_rdata[hit_sel +: 32];
  assign miss_way = inv_found ? inv_way : repl_way;

`ifdef CACHE_PLRU_EN
  // Tree bits {b2,b1,b0}: b0 picks the half (0 = ways 0/1), b1 picks within
  // ways 0/1, b2 within ways 2/3; each bit points at the less recent side.
  logic [2:0] plru_q [8];
  logic [2:0] plru_cur;
  logic       touch_en;
  logic [1:0] touch_way;

  assign plru_cur  = plru_q[idx_q];
  assign repl_way  = plru_cur[0] ? (plru_cur[2] ? 2'd3 : 2'd2)
                                 : (plru_cur[1] ? 2'd1 : 2'd0);
  assign touch_en  = ((state_q == LOOKUP) && hit) || (state_q == WRITE);
  assign touch_way = (state_q == WRITE) ? victim_q : hit_way;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int unsigned s = 0; s < 8; s++) plru_q[s] <= '0;
    end else if (touch_en) begin
      if (touch_way[1]) plru_q[idx_q] <= {~touch_way[0], plru_cur[1], 1'b0};
      else              plru_q[idx_q] <= {plru_cur[2], ~touch_way[0], 1'b1};
    end
  end
`else
  logic [1:0] rr_q;

  assign repl_way = rr_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst)                   rr_q <= '0;
    else if (state_q == WRITE)  rr_q <= rr_q + 2'd1;
  end
`endif

  // State register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_q <= IDLE;
    else      state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (cpu_req_valid) state_d = LOOKUP;
      LOOKUP:  state_d = hit ? RESP : MISS;
      MISS:    if (mem_req_ready) state_d = REFILL;
      REFILL:  if (mem_rdata_valid && (beat_q == 3'd7)) state_d = WRITE;
      WRITE:   state_d = RESP;
      RESP:    if (cpu_resp_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Request, victim, refill buffer and response registers
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      tag_q    <= '0;
      idx_q    <= '0;
      off_q    <= '0;
      victim_q <= '0;
      beat_q   <= '0;
      line_q   <= '0;
      resp_q   <= '0;
    end else begin
      case (state_q)
        IDLE: if (cpu_req_valid) begin
          tag_q <= cpu_req_addr[31:8];
          idx_q <= cpu_req_addr[7:5];
          off_q <= cpu_req_addr[4:2];
        end
        LOOKUP: begin
          if (hit) resp_q   <= hit_word;
          else     victim_q <= miss_way;
        end
        REFILL: if (mem_rdata_valid) begin
          line_q[{beat_q, 5'b0} +: 32] <= mem_rdata;
          beat_q <= beat_q + 3'd1;
        end
        WRITE:   resp_q <= line_q[{off_q, 5'b0} +: 32];
        default: ;
      endcase
    end
  end

  // Output logic
  always_comb begin
    cpu_req_ready   = 1'b0;
    cpu_resp_valid  = 1'b0;
    cpu_resp_data   = '0;
    mem_req_valid   = 1'b0;
    mem_req_addr    = '0;
    mem_rdata_ready = 1'b0;
    tag_raddr       = '0;
    tag_waddr       = '0;
    tag_wen         = '0;
    tag_wdata       = '0;
    data_raddr      = '0;
    data_waddr      = '0;
    data_wen        = '0;
    data_wdata      = '0;
    case (state_q)
      IDLE:   cpu_req_ready = 1'b1;
      LOOKUP: begin
        tag_raddr  = idx_q;
        data_raddr = idx_q;
      end
      MISS: begin
        mem_req_valid = 1'b1;
        mem_req_addr  = {tag_q, idx_q, 5'b0};
      end
      REFILL: mem_rdata_ready = 1'b1;
      WRITE: begin
        tag_wen    = 4'b0001 << victim_q;
        data_wen   = 4'b0001 << victim_q;
        tag_waddr  = idx_q;
        data_waddr = idx_q;
        tag_wdata  = tag_q;
        data_wdata = line_q;
      end
      RESP: begin
        cpu_resp_valid = 1'b1;
        cpu_resp_data  = resp_q;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_cache_ctrl.sv
// tb_cache_ctrl -- self-checking bench for cache_ctrl. Models the external
// tag/data arrays and main memory, runs a directed vector table, a
// reset-during-refill sequence and a randomized phase checked against a
// line-level cache model. Honours CACHE_PLRU_EN for the replacement model.

module tb_cache_ctrl;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          cpu_req_valid = 1'b0;
  logic          cpu_req_ready;
  logic [31:0]   cpu_req_addr = '0;
  logic          cpu_resp_valid;
  logic          cpu_resp_ready = 1'b0;
  logic [31:0]   cpu_resp_data;
  logic          mem_req_valid;
  logic          mem_req_ready = 1'b0;
  logic [31:0]   mem_req_addr;
  logic          mem_rdata_valid = 1'b0;
  logic          mem_rdata_ready;
  logic [31:0]   mem_rdata = '0;
  logic [2:0]    tag_raddr, tag_waddr;
  logic [3:0]    tag_wen;
  logic [23:0]   tag_wdata;
  logic [95:0]   tag_rdata;
  logic [3:0]    tag_valid;
  logic [2:0]    data_raddr, data_waddr;
  logic [3:0]    data_wen;
  logic [255:0]  data_wdata;
  logic [1023:0] data_rdata;

  always #5 clk = ~clk;

  cache_ctrl dut (
    .clk(clk), .rst(rst),
    .cpu_req_valid(cpu_req_valid), .cpu_req_ready(cpu_req_ready), .cpu_req_addr(cpu_req_addr),
    .cpu_resp_valid(cpu_resp_valid), .cpu_resp_ready(cpu_resp_ready), .cpu_resp_data(cpu_resp_data),
    .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready), .mem_req_addr(mem_req_addr),
    .mem_rdata_valid(mem_rdata_valid), .mem_rdata_ready(mem_rdata_ready), .mem_rdata(mem_rdata),
    .tag_raddr(tag_raddr), .tag_waddr(tag_waddr), .tag_wen(tag_wen), .tag_wdata(tag_wdata),
    .tag_rdata(tag_rdata), .tag_valid(tag_valid),
    .data_raddr(data_raddr), .data_waddr(data_waddr), .data_wen(data_wen),
    .data_wdata(data_wdata), .data_rdata(data_rdata)
  );

  // External arrays: combinational read, write on the clock edge.
  logic [23:0]  env_tag  [8][4];
  logic [3:0]   env_val  [8];
  logic [255:0] env_data [8][4];

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int s = 0; s < 8; s++) env_val[s] <= '0;
    end else begin
      for (int w = 0; w < 4; w++) begin
        if (tag_wen[w]) begin
          env_tag[tag_waddr][w] <= tag_wdata;
          env_val[tag_waddr][w] <= 1'b1;
        end
        if (data_wen[w]) env_data[data_waddr][w] <= data_wdata;
      end
    end
  end

  always_comb begin
    tag_rdata  = '0;
    data_rdata = '0;
    tag_valid  = env_val[tag_raddr];
    for (int w = 0; w < 4; w++) begin
      tag_rdata[24*w +: 24]   = env_tag[tag_raddr][w];
      data_rdata[256*w +: 256] = env_data[data_raddr][w];
    end
  end

  int wr_cycles = 0;
  always @(negedge clk) if (tag_wen != 0 || data_wen != 0) wr_cycles++;

  int errors = 0;
  int checks = 0;

  task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Memory contents: each word encodes its set, tag and beat number.
  function automatic logic [31:0] mem_word(input logic [31:0] blk, input int k);
    logic [2:0] hi;
    hi = blk[7:5] - 3'd1;
    return {hi, 1'b0, blk[31:8], 1'b0, 3'(k)};
  endfunction

  function automatic logic [255:0] mem_line(input logic [31:0] blk);
    logic [255:0] l;
    for (int k = 0; k < 8; k++) l[32*k +: 32] = mem_word(blk, k);
    return l;
  endfunction

  function automatic int onehot_way(input logic [3:0] v);
    case (v)
      4'b0001: return 0;
      4'b0010: return 1;
      4'b0100: return 2;
      4'b1000: return 3;
      default: return 9;
    endcase
  endfunction

  // One CPU read with full protocol checking. Called at a falling edge with
  // the controller idle; returns at a falling edge with it idle again.
  task automatic do_read(input string nm, input logic [31:0] addr, input bit exp_hit,
                         input int exp_way, input logic [31:0] exp_data,
                         input int hold, input bit gaps, input bit slow_req);
    logic [31:0] blk, data;
    int t, k, writes, reqs, way, lat, busy, unstable;
    bit done, saw_req;
    blk = {addr[31:5], 5'b0};
    t = 0; k = 0; writes = 0; reqs = 0; way = -1; lat = -1; busy = 0; unstable = 0;
    data = '0; done = 1'b0; saw_req = 1'b0;
    chk({nm, "_req_ready"}, 256'(cpu_req_ready), 256'(1));
    cpu_req_valid = 1'b1;
    cpu_req_addr  = addr;
    @(negedge clk);
    t = 1;
    cpu_req_valid = 1'b0;
    cpu_req_addr  = $urandom;
    while (!done && t < 400) begin
      mem_req_ready   = 1'b0;
      mem_rdata_valid = 1'b0;
      mem_rdata       = $urandom;
      if (cpu_req_ready) busy++;
      if (mem_req_valid) begin
        if (!saw_req) chk({nm, "_mem_addr"}, 256'(mem_req_addr), 256'(blk));
        saw_req = 1'b1;
        mem_req_ready = slow_req ? ($urandom_range(0, 2) == 0) : 1'b1;
        if (mem_req_ready) reqs++;
      end
      if (mem_rdata_ready && (!gaps || (t % 2 == 1))) begin
        mem_rdata_valid = 1'b1;
        mem_rdata       = mem_word(blk, k);
        k++;
      end
      if (tag_wen != 0 || data_wen != 0) begin
        writes++;
        way = onehot_way(tag_wen);
        chk({nm, "_tag_wdata"}, 256'(tag_wdata), 256'(addr[31:8]));
        chk({nm, "_tag_waddr"}, 256'(tag_waddr), 256'(addr[7:5]));
        chk({nm, "_data_waddr"}, 256'(data_waddr), 256'(addr[7:5]));
        chk({nm, "_data_wen"}, 256'(data_wen), 256'(tag_wen));
        chk({nm, "_data_wdata"}, data_wdata, mem_line(blk));
        chk({nm, "_beats"}, 256'(k), 256'(8));
      end
      if (cpu_resp_valid) begin
        lat  = t;
        data = cpu_resp_data;
        for (int h = 0; h < hold; h++) begin
          @(negedge clk);
          t++;
          if (!cpu_resp_valid || cpu_resp_data !== data) unstable++;
          if (cpu_req_ready) busy++;
        end
        cpu_resp_ready = 1'b1;
        @(negedge clk);
        t++;
        cpu_resp_ready = 1'b0;
        chk({nm, "_resp_drop"}, 256'(cpu_resp_valid), 256'(0));
        done = 1'b1;
      end else begin
        @(negedge clk);
        t++;
      end
    end
    mem_req_ready   = 1'b0;
    mem_rdata_valid = 1'b0;
    if (!done) chk({nm, "_timeout"}, 256'(t), 256'(0));
    chk({nm, "_data"}, 256'(data), 256'(exp_data));
    chk({nm, "_miss"}, 256'(saw_req), 256'(!exp_hit));
    chk({nm, "_reqs"}, 256'(reqs), 256'(exp_hit ? 0 : 1));
    chk({nm, "_writes"}, 256'(writes), 256'(exp_hit ? 0 : 1));
    chk({nm, "_way"}, 256'(way), 256'(exp_way));
    chk({nm, "_busy"}, 256'(busy), 256'(0));
    if (hold > 0) chk({nm, "_stable"}, 256'(unstable), 256'(0));
    if (exp_hit) chk({nm, "_latency"}, 256'(lat), 256'(2));
  endtask

  // Reference cache model: which block lives in which way.
  logic [23:0] m_tag [8][4];
  bit          m_val [8][4];
  int          m_rr;
  bit          m_root [8];
  bit          m_left [8];
  bit          m_right[8];

  task automatic model_clear();
    for (int s = 0; s < 8; s++) begin
      for (int w = 0; w < 4; w++) m_val[s][w] = 1'b0;
      m_root[s] = 1'b0; m_left[s] = 1'b0; m_right[s] = 1'b0;
    end
    m_rr = 0;
  endtask

  task automatic model_access(input logic [31:0] addr, output bit hit, output int way);
    int s, victim;
    s = int'(addr[7:5]);
    hit = 1'b0; way = -1;
    for (int w = 0; w < 4; w++)
      if (m_val[s][w] && m_tag[s][w] == addr[31:8]) begin hit = 1'b1; way = w; end
    if (!hit) begin
      victim = -1;
      for (int w = 0; w < 4; w++) if (!m_val[s][w] && victim < 0) victim = w;
`ifdef CACHE_PLRU_EN
      if (victim < 0) victim = m_root[s] ? (m_right[s] ? 3 : 2) : (m_left[s] ? 1 : 0);
`else
      if (victim < 0) victim = m_rr;
`endif
      m_tag[s][victim] = addr[31:8];
      m_val[s][victim] = 1'b1;
      m_rr = (m_rr + 1) % 4;
      way = victim;
    end
    // Tree points away from the way just used.
    if (way < 2) begin m_root[s] = 1'b1; m_left[s]  = (way == 0); end
    else         begin m_root[s] = 1'b0; m_right[s] = (way == 2); end
  endtask

  task automatic reset_dut(input string nm);
    cpu_req_valid = 1'b0; cpu_resp_ready = 1'b0;
    mem_req_ready = 1'b0; mem_rdata_valid = 1'b0;
    rst = 1'b0;
    @(negedge clk);
    @(negedge clk);
    chk({nm, "_rst_resp_valid"}, 256'(cpu_resp_valid), 256'(0));
    chk({nm, "_rst_mem_req"}, 256'(mem_req_valid), 256'(0));
    chk({nm, "_rst_rdata_ready"}, 256'(mem_rdata_ready), 256'(0));
    chk({nm, "_rst_wen"}, 256'({tag_wen, data_wen}), 256'(0));
    rst = 1'b1;
    @(negedge clk);
    chk({nm, "_rst_req_ready"}, 256'(cpu_req_ready), 256'(1));
    model_clear();
  endtask

  typedef struct {
    logic [31:0] addr;
    bit          hit;
    int          way;
    logic [31:0] data;
    int          hold;
    bit          gaps;
    bit          slow;
  } vec_t;

`ifdef CACHE_PLRU_EN
  localparam int REFETCH_WAY = 2;
`else
  localparam int REFETCH_WAY = 1;
`endif

  vec_t tbl [9];

  initial begin
    bit   h;
    int   w, k, wr0;
    logic [31:0] a;

    // Set 1 filled from cold with tags 1..4, then eviction traffic.
    tbl[0] = '{32'h0000_0124, 1'b0, 0,           32'h0000_0011, 0, 1'b0, 1'b0};
    tbl[1] = '{32'h0000_0124, 1'b1, -1,          32'h0000_0011, 0, 1'b0, 1'b0};
    tbl[2] = '{32'h0000_0228, 1'b0, 1,           32'h0000_0022, 5, 1'b1, 1'b1};
    tbl[3] = '{32'h0000_033C, 1'b0, 2,           32'h0000_0037, 0, 1'b0, 1'b0};
    tbl[4] = '{32'h0000_0420, 1'b0, 3,           32'h0000_0040, 0, 1'b1, 1'b0};
    tbl[5] = '{32'h0000_0530, 1'b0, 0,           32'h0000_0054, 1, 1'b0, 1'b0};
    tbl[6] = '{32'h0000_0124, 1'b0, REFETCH_WAY, 32'h0000_0011, 0, 1'b0, 1'b1};
    tbl[7] = '{32'h0000_0420, 1'b1, -1,          32'h0000_0040, 3, 1'b0, 1'b0};
    tbl[8] = '{32'h0000_0040, 1'b0, 0,           32'h2000_0000, 2, 1'b0, 1'b0};

    #1;
    reset_dut("init");
    for (int i = 0; i < 9; i++)
      do_read($sformatf("v%0d", i), tbl[i].addr, tbl[i].hit, tbl[i].way, tbl[i].data,
              tbl[i].hold, tbl[i].gaps, tbl[i].slow);

    // Reset after refill beat 3 must abandon the refill with no array write.
    reset_dut("mid");
    chk("mid_req_ready", 256'(cpu_req_ready), 256'(1));
    cpu_req_valid = 1'b1;
    cpu_req_addr  = 32'h0000_0664;
    @(negedge clk);
    cpu_req_valid = 1'b0;
    k = 0;
    wr0 = wr_cycles;
    for (int c = 0; c < 40 && k < 4; c++) begin
      mem_req_ready   = mem_req_valid;
      mem_rdata_valid = 1'b0;
      if (mem_rdata_ready) begin
        mem_rdata_valid = 1'b1;
        mem_rdata       = mem_word(32'h0000_0660, k);
        k++;
      end
      @(negedge clk);
    end
    chk("mid_beats_sent", 256'(k), 256'(4));
    mem_rdata_valid = 1'b0;
    mem_req_ready   = 1'b0;
    rst = 1'b0;
    @(negedge clk);
    @(negedge clk);
    chk("mid_rdata_ready", 256'(mem_rdata_ready), 256'(0));
    chk("mid_resp_valid", 256'(cpu_resp_valid), 256'(0));
    chk("mid_mem_req", 256'(mem_req_valid), 256'(0));
    rst = 1'b1;
    @(negedge clk);
    chk("mid_req_ready_after", 256'(cpu_req_ready), 256'(1));
    chk("mid_no_write", 256'(wr_cycles - wr0), 256'(0));
    model_clear();
    do_read("mid_refetch", 32'h0000_0664, 1'b0, 0, 32'h4000_0061, 0, 1'b0, 1'b0);

    // Randomized traffic on two sets with six competing tags.
    reset_dut("rnd");
    for (int i = 0; i < 60; i++) begin
      a = {24'($urandom_range(0, 5)), 3'($urandom_range(0, 1)),
           3'($urandom_range(0, 7)), 2'($urandom_range(0, 3))};
      model_access(a, h, w);
      do_read($sformatf("r%0d", i), a, h, h ? -1 : w, mem_word({a[31:5], 5'b0}, int'(a[4:2])),
              int'($urandom_range(0, 3)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("Result: errors=%0d of %0d checks", errors + 1, checks + 1);
    $fatal(1, "watchdog");
  end

endmodule
